// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller: states, instruction
// classes, opcode match patterns, ALUop codes and the per-class static controls.
package legv8_ctrl_pkg;

    localparam int unsigned OPCODE_W = 11;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned ALUOP_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_ADDI = 3'd2,
        CLS_SUBI = 3'd3,
        CLS_LDUR = 3'd4,
        CLS_STUR = 3'd5,
        CLS_CBZ  = 3'd6,
        CLS_B    = 3'd7
    } cls_e;

    // Prefix patterns compare against the top bits of the opcode only.
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               reg2loc;
        logic               alusrc;
        logic               memtoreg;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
    } static_ctrl_t;

    // Datapath controls that stay constant for the whole instruction.
    function automatic static_ctrl_t static_ctrl(input cls_e cls);
        static_ctrl_t c;
        c = '0;
        case (cls)
            CLS_R: c.aluop = ALUOP_FUNCT;
            CLS_ADDI, CLS_SUBI: begin
                c.alusrc = 1'b1;
                c.aluop  = ALUOP_FUNCT;
            end
            CLS_LDUR: begin
                c.reg2loc  = 1'b1;
                c.alusrc   = 1'b1;
                c.memtoreg = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            CLS_STUR: begin
                c.reg2loc = 1'b1;
                c.alusrc  = 1'b1;
                c.aluop   = ALUOP_ADD;
            end
            CLS_CBZ: begin
                c.reg2loc = 1'b1;
                c.branch  = 1'b1;
                c.aluop   = ALUOP_PASS;
            end
            CLS_B: begin
                c.branch = 1'b1;
                c.aluop  = ALUOP_PASS;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/legv8_opcode_classify.sv
// Combinational opcode decoder: maps an 11-bit LEGv8 opcode to an instruction
// class and flags anything unsupported as illegal.
module legv8_opcode_classify
    import legv8_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [2:0]          cls_c,
    output logic                illegal_c
);

    cls_e cls;

    always_comb begin
        cls = CLS_NONE;
        if (opcode[10:5] == OPC_B) begin
            cls = CLS_B;
        end else if (opcode[10:3] == OPC_CBZ) begin
            cls = CLS_CBZ;
        end else if (opcode[10:1] == OPC_ADDI) begin
            cls = CLS_ADDI;
        end else if (opcode[10:1] == OPC_SUBI) begin
            cls = CLS_SUBI;
        end else if (opcode == OPC_ADD || opcode == OPC_SUB ||
                     opcode == OPC_AND || opcode == OPC_ORR) begin
            cls = CLS_R;
        end else if (opcode == OPC_LDUR) begin
            cls = CLS_LDUR;
        end else if (opcode == OPC_STUR) begin
            cls = CLS_STUR;
        end
    end

    assign cls_c     = cls;
    assign illegal_c = (cls == CLS_NONE);

endmodule

// File: rtl/multicycle_control_fsm.sv
// LEGv8 multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory
// handshake timeout. Define CTRL_PERF_CNT_EN to add cycle/retired counters.
module multicycle_control_fsm
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255,
    parameter int unsigned WAIT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                alu_zero_i,
    input  logic                imem_ready_i,
    input  logic                dmem_ready_i,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2Loc,
    output logic                ALUsrc,
    output logic                memtoReg,
    output logic                regWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic                branch,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic [STATE_W-1:0]  state_o,
    output logic                illegal_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         retired_cnt
`endif
);

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic [2:0]        dec_cls_raw;
    logic              dec_illegal;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_c;
    logic              illegal_q;
    static_ctrl_t      sctrl;

    legv8_opcode_classify u_classify (
        .opcode    (opcode_i),
        .cls_c     (dec_cls_raw),
        .illegal_c (dec_illegal)
    );

    assign dec_cls = cls_e'(dec_cls_raw);

    // Last permitted low-ready cycle; a ready in this same cycle still wins.
    assign timeout_c = (WAIT_LIMIT != 0) && (wait_q == WAIT_W'(WAIT_LIMIT - 1));

    // Next-state, class capture and wait counter.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                wait_d = '0;
                case (cls_q)
                    CLS_R, CLS_ADDI, CLS_SUBI: state_d = ST_WB;
                    CLS_LDUR, CLS_STUR:        state_d = ST_MEM;
                    CLS_B, CLS_CBZ:            state_d = ST_FETCH;
                    default:                   state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready_i) begin
                    wait_d  = '0;
                    state_d = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_WB: begin
                wait_d  = '0;
                state_d = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            wait_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            if (state_d == ST_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Output decode; DECODE uses the live classification since the class
    // register only loads at the end of that cycle.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        sctrl    = '0;
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            sctrl = static_ctrl((state_q == ST_DECODE) ? dec_cls : cls_q);
        end
        case (state_q)
            ST_FETCH: begin
                imem_req = !rst;
                ir_write = !rst && imem_ready_i;
            end
            ST_EXEC: begin
                if (cls_q == CLS_B) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end else if (cls_q == CLS_CBZ) begin
                    pc_write = 1'b1;
                    pc_src   = alu_zero_i;
                end
            end
            ST_MEM: begin
                memRead  = (cls_q == CLS_LDUR);
                memWrite = (cls_q == CLS_STUR);
                pc_write = (cls_q == CLS_STUR) && dmem_ready_i;
            end
            ST_WB: begin
                regWrite = 1'b1;
                pc_write = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
        reg2Loc  = sctrl.reg2loc;
        ALUsrc   = sctrl.alusrc;
        memtoReg = sctrl.memtoreg;
        branch   = sctrl.branch;
        ALUop    = sctrl.aluop;
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state_q != ST_TRAP) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (pc_write) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues one expected
// output vector per cycle, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] opcode_i;
    logic        alu_zero_i;
    logic        imem_ready_i;
    logic        dmem_ready_i;
    logic        imem_req, ir_write, pc_write, pc_src;
    logic        reg2Loc, ALUsrc, memtoReg, regWrite;
    logic        memRead, memWrite, branch;
    logic [1:0]  ALUop;
    logic [2:0]  state_o;
    logic        illegal_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_control_fsm #(.WAIT_LIMIT(4), .WAIT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode_i),
        .alu_zero_i   (alu_zero_i),
        .imem_ready_i (imem_ready_i),
        .dmem_ready_i (dmem_ready_i),
        .imem_req     (imem_req),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg2Loc      (reg2Loc),
        .ALUsrc       (ALUsrc),
        .memtoReg     (memtoReg),
        .regWrite     (regWrite),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .branch       (branch),
        .ALUop        (ALUop),
        .state_o      (state_o),
        .illegal_o    (illegal_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .retired_cnt  (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    // Static control sets {reg2Loc, ALUsrc, memtoReg, branch, ALUop}.
    localparam logic [5:0] S_0   = 6'b000000;
    localparam logic [5:0] S_R   = 6'b000010;
    localparam logic [5:0] S_I   = 6'b010010;
    localparam logic [5:0] S_LD  = 6'b111000;
    localparam logic [5:0] S_ST  = 6'b110000;
    localparam logic [5:0] S_CBZ = 6'b100101;
    localparam logic [5:0] S_B   = 6'b000101;

    typedef struct {
        logic [16:0] vec;
        string       name;
        int          idx;
    } exp_t;

    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    step  = 0;
    string cur_name = "init";

    wire logic [16:0] act = {state_o, imem_req, ir_write, pc_write, pc_src,
                             reg2Loc, ALUsrc, memtoReg, regWrite, memRead,
                             memWrite, branch, ALUop, illegal_o};

    function automatic logic [16:0] e(input logic [2:0] st, input logic req, irw,
                                      pcw, pcs, rw, mr, mw, ill, input logic [5:0] s);
        return {st, req, irw, pcw, pcs, s[5], s[4], s[3], rw, mr, mw, s[2], s[1:0], ill};
    endfunction

    task automatic cyc(input logic r, input logic [10:0] opc, input logic imr,
                       input logic dmr, input logic z, input logic [16:0] ex);
        exp_t t;
        @(posedge clk);
        #1;
        rst          = r;
        opcode_i     = opc;
        imem_ready_i = imr;
        dmem_ready_i = dmr;
        alu_zero_i   = z;
        t.vec  = ex;
        t.name = cur_name;
        t.idx  = step;
        step++;
        sb_q.push_back(t);
    endtask

    task automatic fetch(input logic [10:0] opc);
        cyc(1'b0, opc, 1'b1, 1'b1, 1'b0, e(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, S_0));
    endtask

    // FETCH, DECODE, EXEC, WB for register/immediate ALU instructions.
    task automatic alu_instr(input logic [10:0] opc, input logic [5:0] s);
        fetch(opc);
        cyc(1'b0, opc, 1'b1, 1'b1, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, s));
        cyc(1'b0, opc, 1'b1, 1'b1, 1'b0, e(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, s));
        cyc(1'b0, opc, 1'b1, 1'b1, 1'b0, e(3'd4, 0, 0, 1, 0, 1, 0, 0, 0, s));
    endtask

    always @(negedge clk) begin
        exp_t t;
        if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            total++;
            if (act !== t.vec) begin
                bad++;
                $display("FAIL %s[%0d] got=%b want=%b", t.name, t.idx, act, t.vec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        opcode_i     = '0;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        alu_zero_i   = 1'b0;

        cur_name = "reset";
        repeat (2) cyc(1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, e(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, S_0));

        cur_name = "add";
        alu_instr(OP_ADD, S_R);
        cur_name = "orr";
        alu_instr(OP_ORR, S_R);
        cur_name = "addi";
        alu_instr(OP_ADDI, S_I);

        cur_name = "subi_fetch_wait";
        repeat (2) cyc(1'b0, OP_SUBI, 1'b0, 1'b1, 1'b0, e(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, S_0));
        alu_instr(OP_SUBI, S_I);

        cur_name = "ldur_wait3";
        fetch(OP_LDUR);
        cyc(1'b0, OP_LDUR, 1'b1, 1'b0, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_LD));
        cyc(1'b0, OP_LDUR, 1'b1, 1'b0, 1'b0, e(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, S_LD));
        repeat (3) cyc(1'b0, OP_LDUR, 1'b1, 1'b0, 1'b0, e(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, S_LD));
        cyc(1'b0, OP_LDUR, 1'b1, 1'b1, 1'b0, e(3'd3, 0, 0, 0, 0, 0, 1, 0, 0, S_LD));
        cyc(1'b0, OP_LDUR, 1'b1, 1'b1, 1'b0, e(3'd4, 0, 0, 1, 0, 1, 0, 0, 0, S_LD));

        cur_name = "cbz_taken";
        fetch(OP_CBZ);
        cyc(1'b0, OP_CBZ, 1'b1, 1'b1, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_CBZ));
        cyc(1'b0, OP_CBZ, 1'b1, 1'b1, 1'b1, e(3'd2, 0, 0, 1, 1, 0, 0, 0, 0, S_CBZ));
        cur_name = "cbz_not_taken";
        fetch(OP_CBZ);
        cyc(1'b0, OP_CBZ, 1'b1, 1'b1, 1'b1, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_CBZ));
        cyc(1'b0, OP_CBZ, 1'b1, 1'b1, 1'b0, e(3'd2, 0, 0, 1, 0, 0, 0, 0, 0, S_CBZ));

        cur_name = "b";
        fetch(OP_B);
        cyc(1'b0, OP_B, 1'b1, 1'b1, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_B));
        cyc(1'b0, OP_B, 1'b1, 1'b1, 1'b0, e(3'd2, 0, 0, 1, 1, 0, 0, 0, 0, S_B));

        cur_name = "stur_fast";
        fetch(OP_STUR);
        cyc(1'b0, OP_STUR, 1'b1, 1'b1, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        cyc(1'b0, OP_STUR, 1'b1, 1'b1, 1'b0, e(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        cyc(1'b0, OP_STUR, 1'b1, 1'b1, 1'b0, e(3'd3, 0, 0, 1, 0, 0, 0, 1, 0, S_ST));

        cur_name = "stur_timeout";
        fetch(OP_STUR);
        cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        repeat (4) cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, S_ST));
        repeat (5) cyc(1'b0, OP_STUR, 1'b1, 1'b1, 1'b1, e(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, S_0));

        cur_name = "reset_from_trap";
        cyc(1'b1, OP_STUR, 1'b1, 1'b1, 1'b0, e(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, S_0));

        cur_name = "stur_rst_mid_mem";
        fetch(OP_STUR);
        cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, S_ST));
        cyc(1'b0, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd3, 0, 0, 0, 0, 0, 0, 1, 0, S_ST));
        cyc(1'b1, OP_STUR, 1'b1, 1'b0, 1'b0, e(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, S_0));

        cur_name = "illegal";
        fetch(OP_BAD);
        cyc(1'b0, OP_BAD, 1'b1, 1'b1, 1'b0, e(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, S_0));
        cur_name = "trap_hold";
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, OP_ADD, 1'b1, 1'b1, 1'b1, e(3'd7, 0, 0, 0, 0, 0, 0, 0, 1, S_0));
        end

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
